// File: rtl/usb_pkg.sv
// ============================================================================
// usb_pkg : shared buffer-mode enum, capacity default and AHB size helpers
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package usb_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_RX   = 2'd1,
    MODE_TX   = 2'd2
  } buf_mode_t;

  localparam int unsigned CAPACITY_DEFAULT = 64;

  localparam logic [1:0] SIZE_INVALID = 2'd0;
  localparam logic [1:0] SIZE_1B      = 2'd1;
  localparam logic [1:0] SIZE_2B      = 2'd2;
  localparam logic [1:0] SIZE_4B      = 2'd3;

  // Byte count of an AHB access; eight bits so occupancy sums never wrap.
  function automatic logic [7:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_1B: size_bytes = 8'd1;
      SIZE_2B: size_bytes = 8'd2;
      SIZE_4B: size_bytes = 8'd4;
      default: size_bytes = 8'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/buffer_ctrl.sv
// ============================================================================
// buffer_ctrl : endpoint data-buffer owner FSM and USB/AHB strobe arbiter
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module buffer_ctrl
  import usb_pkg::*;
#(
  parameter int unsigned CAPACITY = CAPACITY_DEFAULT
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [6:0] buffer_occ,
  input  logic       usb_rx_valid,
  output logic       usb_rx_ready,
  input  logic       usb_rx_done,
  input  logic       usb_tx_req,
  output logic       usb_tx_ack,
  input  logic       usb_tx_done,
  input  logic       pkt_start_rx,
  input  logic       ahb_rd_req,
  input  logic       ahb_wr_req,
  input  logic [1:0] ahb_size,
  output logic       ahb_ack,
  output logic       ahb_err,
  input  logic       ahb_flush,
  output logic [1:0] mode,
  output logic       store_rx_data,
  output logic [1:0] get_rx_data,
  output logic [1:0] store_tx_data,
  output logic       get_tx_data,
  output logic       clear,
  output logic       overflow
);

  localparam logic [7:0] CAP8 = 8'(CAPACITY);

  buf_mode_t  state_q, state_d;
  logic       rx_done_q, rx_done_d;
  logic       tx_done_q, tx_done_d;
  logic       ovf_q, ovf_d;
  logic [7:0] occ_ext;
  logic [7:0] need_bytes;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= MODE_IDLE;
      rx_done_q <= 1'b0;
      tx_done_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_done_q <= rx_done_d;
      tx_done_q <= tx_done_d;
      ovf_q     <= ovf_d;
    end
  end

  assign mode     = state_q;
  assign overflow = ovf_q;

  // Outputs are held low while n_rst is asserted, even with requests pending.
  always_comb begin
    state_d       = state_q;
    rx_done_d     = rx_done_q;
    tx_done_d     = tx_done_q;
    ovf_d         = ovf_q;
    usb_rx_ready  = 1'b0;
    usb_tx_ack    = 1'b0;
    ahb_ack       = 1'b0;
    ahb_err       = 1'b0;
    store_rx_data = 1'b0;
    get_rx_data   = 2'd0;
    store_tx_data = 2'd0;
    get_tx_data   = 1'b0;
    clear         = 1'b0;
    occ_ext       = {1'b0, buffer_occ};
    need_bytes    = size_bytes(ahb_size);

    if (n_rst) begin
      if (ahb_flush) begin
        clear     = 1'b1;
        state_d   = MODE_IDLE;
        rx_done_d = 1'b0;
        tx_done_d = 1'b0;
        ovf_d     = 1'b0;
      end else begin
        case (state_q)
          MODE_IDLE: begin
            rx_done_d = 1'b0;
            tx_done_d = 1'b0;
            if (pkt_start_rx) begin
              state_d = MODE_RX;
            end else if (ahb_wr_req) begin
              state_d = MODE_TX;
            end
            if (ahb_rd_req || (ahb_wr_req && ahb_size == SIZE_INVALID)) begin
              ahb_err = 1'b1;
            end
          end

          MODE_RX: begin
            rx_done_d = rx_done_q | usb_rx_done;
            if (usb_rx_valid) begin
              if (occ_ext < CAP8) begin
                usb_rx_ready  = 1'b1;
                store_rx_data = 1'b1;
              end else begin
                ovf_d = 1'b1;
              end
            end
            if (ahb_wr_req || (ahb_rd_req && ahb_size == SIZE_INVALID)) begin
              ahb_err = 1'b1;
            end else if (ahb_rd_req && !store_rx_data) begin
              if (occ_ext >= need_bytes) begin
                get_rx_data = ahb_size;
                ahb_ack     = 1'b1;
              end else if (rx_done_q) begin
                // Packet is complete: the short read can never be satisfied.
                ahb_err = 1'b1;
              end
            end
            if (rx_done_q && occ_ext == 8'd0) begin
              state_d   = MODE_IDLE;
              rx_done_d = 1'b0;
            end
          end

          MODE_TX: begin
            tx_done_d = tx_done_q | usb_tx_done;
            if (usb_tx_req && occ_ext != 8'd0) begin
              usb_tx_ack  = 1'b1;
              get_tx_data = 1'b1;
            end
            if (ahb_rd_req || (ahb_wr_req && ahb_size == SIZE_INVALID)) begin
              ahb_err = 1'b1;
            end else if (ahb_wr_req && !get_tx_data &&
                         (occ_ext + need_bytes) <= CAP8) begin
              store_tx_data = ahb_size;
              ahb_ack       = 1'b1;
            end
            if (tx_done_q && occ_ext == 8'd0) begin
              state_d   = MODE_IDLE;
              tx_done_d = 1'b0;
            end
          end

          default: state_d = MODE_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_buffer_ctrl.sv
// ============================================================================
// tb_buffer_ctrl : directed self-checking bench for buffer_ctrl
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_buffer_ctrl;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [6:0] buffer_occ;
  logic       usb_rx_valid = 1'b0, usb_rx_ready;
  logic       usb_rx_done = 1'b0;
  logic       usb_tx_req = 1'b0, usb_tx_ack;
  logic       usb_tx_done = 1'b0;
  logic       pkt_start_rx = 1'b0;
  logic       ahb_rd_req = 1'b0, ahb_wr_req = 1'b0;
  logic [1:0] ahb_size = 2'd0;
  logic       ahb_ack, ahb_err;
  logic       ahb_flush = 1'b0;
  logic [1:0] mode;
  logic       store_rx_data;
  logic [1:0] get_rx_data;
  logic [1:0] store_tx_data;
  logic       get_tx_data;
  logic       clear;
  logic       overflow;

  int occ = 0;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  buffer_ctrl #(.CAPACITY(64)) dut (
    .clk(clk), .n_rst(n_rst), .buffer_occ(buffer_occ),
    .usb_rx_valid(usb_rx_valid), .usb_rx_ready(usb_rx_ready),
    .usb_rx_done(usb_rx_done), .usb_tx_req(usb_tx_req),
    .usb_tx_ack(usb_tx_ack), .usb_tx_done(usb_tx_done),
    .pkt_start_rx(pkt_start_rx), .ahb_rd_req(ahb_rd_req),
    .ahb_wr_req(ahb_wr_req), .ahb_size(ahb_size), .ahb_ack(ahb_ack),
    .ahb_err(ahb_err), .ahb_flush(ahb_flush), .mode(mode),
    .store_rx_data(store_rx_data), .get_rx_data(get_rx_data),
    .store_tx_data(store_tx_data), .get_tx_data(get_tx_data),
    .clear(clear), .overflow(overflow)
  );

  function automatic int nbytes(input logic [1:0] s);
    case (s)
      2'd1:    return 1;
      2'd2:    return 2;
      2'd3:    return 4;
      default: return 0;
    endcase
  endfunction

  // Behavioural data buffer: occupancy follows the strobes, reset by n_rst.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) occ <= 0;
    else if (clear) occ <= 0;
    else occ <= occ + int'(store_rx_data) - nbytes(get_rx_data)
                    + nbytes(store_tx_data) - int'(get_tx_data);
  end
  assign buffer_occ = 7'(occ);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst mode", mode, 0);
    check("rst ack", ahb_ack, 0);
    check("rst err", ahb_err, 0);
    check("rst clear", clear, 0);
    check("rst ovf", overflow, 0);
    @(negedge clk); n_rst = 1'b1;

    // RX: 8 bytes, done, two 4-byte reads, return to IDLE
    @(negedge clk); pkt_start_rx = 1'b1; #1 check("A idle pre", mode, 0);
    @(negedge clk); pkt_start_rx = 1'b0; #1 check("A mode rx", mode, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); usb_rx_valid = 1'b1;
      #1 check("A store", store_rx_data, 1);
      check("A ready", usb_rx_ready, 1);
    end
    @(negedge clk); usb_rx_valid = 1'b0; usb_rx_done = 1'b1;
    #1 check("A occ8", occ, 8);
    @(negedge clk); usb_rx_done = 1'b0; ahb_rd_req = 1'b1; ahb_size = 2'd3;
    #1 check("A get1", get_rx_data, 3);
    check("A ack1", ahb_ack, 1);
    @(negedge clk); #1 check("A get2", get_rx_data, 3);
    @(negedge clk); ahb_rd_req = 1'b0;
    #1 check("A occ0", occ, 0);
    check("A mode still rx", mode, 1);
    @(negedge clk); #1 check("A mode idle", mode, 0);

    // TX: 16 four-byte writes fill 64, 17th stalls until 4 bytes drained
    @(negedge clk); ahb_wr_req = 1'b1; ahb_size = 2'd3;
    #1 check("B idle no ack", ahb_ack, 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); #1 check("B wr ack", ahb_ack, 1);
      check("B store_tx", store_tx_data, 3);
    end
    @(negedge clk); #1 check("B occ64", occ, 64);
    check("B full stall", ahb_ack, 0);
    check("B full nostrobe", store_tx_data, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); usb_tx_req = 1'b1;
      #1 check("B tx_ack", usb_tx_ack, 1);
      check("B usb prio", ahb_ack, 0);
    end
    @(negedge clk); usb_tx_req = 1'b0;
    #1 check("B 17th ack", ahb_ack, 1);
    check("B 17th store", store_tx_data, 3);
    @(negedge clk); ahb_wr_req = 1'b0; usb_tx_req = 1'b1;
    repeat (44) @(negedge clk);
    usb_tx_req = 1'b0;
    #1 check("B occ20", occ, 20);

    // Flush in TX at occupancy 20 with a writable request pending
    ahb_flush = 1'b1; ahb_wr_req = 1'b1;
    #1 check("C clear", clear, 1);
    check("C no ack", ahb_ack, 0);
    check("C no store", store_tx_data, 0);
    @(negedge clk); ahb_flush = 1'b0; ahb_wr_req = 1'b0;
    #1 check("C mode idle", mode, 0);
    check("C clear once", clear, 0);
    check("C occ0", occ, 0);

    // Read in IDLE is rejected
    @(negedge clk); ahb_rd_req = 1'b1; ahb_size = 2'd1;
    #1 check("D idle rd err", ahb_err, 1);
    check("D idle rd nostrobe", get_rx_data, 0);
    @(negedge clk); ahb_rd_req = 1'b0;

    // RX overflow at capacity, protocol errors, flush clears overflow
    @(negedge clk); pkt_start_rx = 1'b1;
    @(negedge clk); pkt_start_rx = 1'b0; usb_rx_valid = 1'b1;
    repeat (64) @(negedge clk);
    #1 check("E occ64", occ, 64);
    check("E full ready", usb_rx_ready, 0);
    check("E full store", store_rx_data, 0);
    @(negedge clk); usb_rx_valid = 1'b0;
    #1 check("E overflow", overflow, 1);
    @(negedge clk); ahb_wr_req = 1'b1; ahb_size = 2'd1;
    #1 check("E wr in rx err", ahb_err, 1);
    @(negedge clk); ahb_wr_req = 1'b0; ahb_rd_req = 1'b1; ahb_size = 2'd0;
    #1 check("E size0 err", ahb_err, 1);
    check("E size0 nostrobe", get_rx_data, 0);
    @(negedge clk); ahb_rd_req = 1'b0; ahb_flush = 1'b1;
    #1 check("E flush clear", clear, 1);
    @(negedge clk); ahb_flush = 1'b0;
    #1 check("E ovf cleared", overflow, 0);
    check("E mode idle", mode, 0);

    // USB priority at occ 6, then short read after done
    @(negedge clk); pkt_start_rx = 1'b1;
    @(negedge clk); pkt_start_rx = 1'b0; usb_rx_valid = 1'b1;
    repeat (6) @(negedge clk);
    ahb_rd_req = 1'b1; ahb_size = 2'd3;
    #1 check("F occ6", occ, 6);
    check("F store wins", store_rx_data, 1);
    check("F no get", get_rx_data, 0);
    check("F no ack", ahb_ack, 0);
    @(negedge clk); usb_rx_valid = 1'b0;
    #1 check("F late ack", ahb_ack, 1);
    check("F late get", get_rx_data, 3);
    @(negedge clk); ahb_size = 2'd2;
    #1 check("F rd2 get", get_rx_data, 2);
    @(negedge clk); ahb_rd_req = 1'b0; usb_rx_done = 1'b1;
    #1 check("F occ1", occ, 1);
    @(negedge clk); usb_rx_done = 1'b0; ahb_rd_req = 1'b1; ahb_size = 2'd2;
    #1 check("F short err", ahb_err, 1);
    check("F short noget", get_rx_data, 0);
    check("F short noack", ahb_ack, 0);
    @(negedge clk); ahb_size = 2'd1;
    #1 check("F rd1 ack", ahb_ack, 1);
    @(negedge clk); ahb_rd_req = 1'b0;
    @(negedge clk); #1 check("F mode idle", mode, 0);

    // Asynchronous reset in the middle of an RX packet
    @(negedge clk); pkt_start_rx = 1'b1;
    @(negedge clk); pkt_start_rx = 1'b0; usb_rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("G mode rx", mode, 1);
    ahb_rd_req = 1'b1; ahb_size = 2'd1;
    n_rst = 1'b0;
    #1 check("G rst mode", mode, 0);
    check("G rst ready", usb_rx_ready, 0);
    check("G rst store", store_rx_data, 0);
    check("G rst err", ahb_err, 0);
    check("G rst ack", ahb_ack, 0);
    usb_rx_valid = 1'b0; ahb_rd_req = 1'b0;
    @(negedge clk); n_rst = 1'b1;
    @(negedge clk); #1 check("G after rst mode", mode, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
